prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Writer side of the program memory: fills the Psize x Isize instruction store from a byte stream.
//  Bytes arrive over a valid/ready link from the host/UART side and are packed into Isize-bit words.
//  Words are written at sequential addresses 0..2^Psize-1. The CPU is held via cpu_hold until load ends.
//  Sits between the serial receiver and the writable program memory, alongside the picoMIPS core.
// PARAMETERS
//  Psize  4   program memory address width; 2^Psize words are loaded per run
//  Isize  20  instruction width; NB = ceil(Isize/8) bytes per word (localparam, 3 at default)
// PORTS
//  clk       in   1      system clock, all state on rising edge
//  reset     in   1      asynchronous, active-high reset
//  start     in   1      begin a load run (sampled in IDLE/DONE only)
//  rx_data   in   8      incoming byte
//  rx_valid  in   1      rx_data valid
//  rx_ready  out  1      loader accepts byte this cycle
//  wr_en     out  1      program memory write strobe, one cycle per word
//  wr_addr   out  Psize  program memory write address
//  wr_data   out  Isize  program memory write data
//  cpu_hold  out  1      hold CPU (PC at 0) while loading
//  busy      out  1      load run in progress
//  done      out  1      run completed; sticky until next start or reset
//  err       out  1      checksum failure (see CONFIGURATION); sticky like done
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, all outputs 0, addr=0, byte count=0, shift reg=0.
//    A partially assembled word is discarded, no wr_en is issued, and the next start begins at addr 0.
//  - States: IDLE, COLLECT, WRITE, [CHECK], DONE.
//  - IDLE/DONE: on start=1, go to COLLECT next cycle. Clear addr, byte count, done and err.
//  - COLLECT: rx_ready=1. A byte is accepted on a clock edge when rx_valid&&rx_ready.
//    Each accepted byte is shifted in: shreg <= {shreg[8*NB-9:0], rx_data}. Big-endian: first byte is most significant.
//    On the NB-th accepted byte, go to WRITE.
//  - WRITE (exactly 1 cycle): rx_ready=0, wr_en=1, wr_addr=addr, wr_data=shreg[Isize-1:0].
//    Upper 8*NB-Isize bits of the first byte are discarded.
//    Transitions from WRITE:
//      * addr==2^Psize-1 -> DONE (or CHECK if feature enabled).
//      * otherwise addr<=addr+1 and back to COLLECT. No wrap; the last address ends the run.
//  - Latency: wr_en is asserted in the cycle after the edge accepting the word's last byte.
//  - busy=1 and cpu_hold=1 in COLLECT/WRITE/CHECK; both 0 in IDLE/DONE. Registered outputs.
//  - start while busy is ignored. rx_valid in IDLE/DONE is ignored (rx_ready=0, bytes not consumed).
//  - done rises on entry to DONE and stays high until start or reset.
//  - wr_addr/wr_data are don't-care when wr_en=0; the bench checks them only on wr_en.
// CONFIGURATION
//  PROG_LOADER_CHECKSUM_EN defined:
//    * A running 8-bit sum (mod 256) covers every accepted byte.
//    * After the last WRITE, enter CHECK with rx_ready=1. Accept one checksum byte, then go to DONE.
//    * err=1 if (sum + checksum byte) mod 256 != 0. Memory writes already issued are not undone.
//  Not defined: no CHECK state and no sum register; err is tied to 0; WRITE of the last word goes directly to DONE.
// TESTING
//  1 Assert reset mid-cycle, no clock -> all outputs 0 immediately; after release, state IDLE, rx_ready=0.
//  2 Psize=4: pulse start, stream 48 bytes with word0 = FA BC DE ->
//    * wr_en at addr 0 with data 0xABCDE; 16 writes at addr 0..15 in order;
//    * done=1 and cpu_hold=0 after the last write.
//  3 Random rx_valid gaps (valid low 0-3 cycles) -> identical write sequence to test 2.
//    rx_ready=0 on every WRITE cycle; no byte lost or duplicated.
//  4 Pulse reset after the 2nd byte of word 5 -> no write for addr 5. Outputs 0.
//    A fresh start then writes addr 0 first.
//  5 Pulse start while busy -> ignored, address sequence continues. done stays 1 across idle cycles until next start.
//  6 With PROG_LOADER_CHECKSUM_EN defined:
//    * correct checksum byte (two's complement of the byte sum) -> done=1, err=0;
//    * checksum off by 1 -> done=1, err=1.

Source files
------------

// File: rtl/prog_loader.sv
// Program-memory loader: packs a big-endian byte stream into Isize-bit words and writes them to addr 0..2^Psize-1.
// Latency: wr_en pulses the cycle after the edge that accepts a word's last byte; done follows the last write.
// Backpressure: rx_ready is high only while collecting bytes (and the checksum byte); it drops for the one write cycle.
//
// Ports:
//   i_clk, i_reset          clock; asynchronous active-high reset
//   i_start                 begins a load run (honoured only when idle or done)
//   i_rx_data/_valid        incoming byte stream; o_rx_ready accepts a byte
//   o_wr_en/_addr/_data     program memory write port, one strobe per word
//   o_cpu_hold, o_busy      high for the whole run
//   o_done, o_err           sticky run-complete and checksum-failure flags
// Optional feature: define PROG_LOADER_CHECKSUM_EN to require a trailing checksum byte
// (byte sum of the image plus the checksum byte must be 0 mod 256); otherwise o_err is 0.
module prog_loader #(
    parameter int Psize = 4,
    parameter int Isize = 20
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_valid,
    output logic             o_rx_ready,
    output logic             o_wr_en,
    output logic [Psize-1:0] o_wr_addr,
    output logic [Isize-1:0] o_wr_data,
    output logic             o_cpu_hold,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);
    localparam int NB = (Isize + 7) / 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [Psize-1:0] LAST_ADDR = {Psize{1'b1}};
    localparam logic [CW-1:0]    LAST_BYTE = CW'(NB - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [Psize-1:0] r_addr;
    logic [CW-1:0]    r_cnt;
    logic [Isize-1:0] r_shreg;
    logic             r_done;
    logic             w_rx_ready;
    logic             w_accept;
    logic             w_idle;

    // Outputs decode straight from the state register, so they change only on a clock
    // edge or on reset (which forces IDLE and therefore all-zero outputs at once).
    assign w_idle     = (r_state == S_IDLE) || (r_state == S_DONE);
`ifdef PROG_LOADER_CHECKSUM_EN
    assign w_rx_ready = (r_state == S_COLLECT) || (r_state == S_CHECK);
`else
    assign w_rx_ready = (r_state == S_COLLECT);
`endif
    assign w_accept   = i_rx_valid && w_rx_ready;

    assign o_rx_ready = w_rx_ready;
    assign o_wr_en    = (r_state == S_WRITE);
    assign o_wr_addr  = r_addr;
    assign o_wr_data  = r_shreg;
    assign o_busy     = !w_idle;
    assign o_cpu_hold = !w_idle;
    assign o_done     = r_done;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) w_next = S_COLLECT;
            end
            S_COLLECT: begin
                if (w_accept && (r_cnt == LAST_BYTE)) w_next = S_WRITE;
            end
            S_WRITE: begin
                if (r_addr == LAST_ADDR) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    w_next = S_CHECK;
`else
                    w_next = S_DONE;
`endif
                end else begin
                    w_next = S_COLLECT;
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (w_accept) w_next = S_DONE;
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] r_sum;
    logic       r_err;
    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_addr  <= '0;
            r_cnt   <= '0;
            r_shreg <= '0;
            r_done  <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_sum   <= '0;
            r_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_addr <= '0;
                        r_cnt  <= '0;
                        r_done <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_sum  <= '0;
                        r_err  <= 1'b0;
`endif
                    end
                end
                S_COLLECT: begin
                    if (w_accept) begin
                        // Only Isize bits are kept: the unused top bits of the first
                        // (most significant) byte shift out of the register.
                        r_shreg <= Isize'({r_shreg, i_rx_data});
                        r_cnt   <= (r_cnt == LAST_BYTE) ? '0 : r_cnt + CW'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_sum   <= r_sum + i_rx_data;
`endif
                    end
                end
                S_WRITE: begin
                    if (r_addr == LAST_ADDR) begin
`ifndef PROG_LOADER_CHECKSUM_EN
                        r_done <= 1'b1;
`endif
                    end else begin
                        r_addr <= r_addr + Psize'(1);
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (w_accept) begin
                        r_done <= 1'b1;
                        r_err  <= ((r_sum + i_rx_data) != 8'd0);
                    end
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;
    localparam int PS = 4;
    localparam int IS = 20;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    rx_data = 8'd0;
    logic          rx_valid = 1'b0;
    logic          rx_ready, wr_en, cpu_hold, busy, done, err;
    logic [PS-1:0] wr_addr;
    logic [IS-1:0] wr_data;

    int total = 0;
    int bad = 0;
    logic [7:0] sum;
    logic [PS+IS-1:0] exp_q[$];

    prog_loader #(.Psize(PS), .Isize(IS)) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start),
        .i_rx_data(rx_data), .i_rx_valid(rx_valid), .o_rx_ready(rx_ready),
        .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
        .o_cpu_hold(cpu_hold), .o_busy(busy), .o_done(done), .o_err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Word pattern: word 0 is 0xABCDE, others differ per index.
    function automatic logic [IS-1:0] word_of(input int w);
        return 20'hABCDE ^ (20'(w) * 20'h01111);
    endfunction

    // Monitor: every write must match the next expected {addr,data}.
    always @(negedge clk) begin
        logic [PS+IS-1:0] e;
        if (!reset && wr_en === 1'b1) begin
            chk("wr_rx_ready_low", {31'd0, rx_ready}, 32'd0);
            chk("wr_busy_hold", {30'd0, busy, cpu_hold}, 32'd3);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write actual addr=%0d data=%h required=no write", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", {28'd0, wr_addr}, {28'd0, e[PS+IS-1:IS]});
                chk("wr_data", {12'd0, wr_data}, {12'd0, e[IS-1:0]});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        while (rx_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            total++;
            bad++;
            $display("FAIL rx_ready_timeout actual=0 required=1");
        end
        @(negedge clk);
        rx_valid = 1'b0;
        sum = sum + b;
    endtask

    // Sends nbytes of word w (first byte carries junk in its upper nibble).
    task automatic send_word(input int w, input int nbytes, input int gapmax, input bit push);
        logic [IS-1:0] d;
        logic [3:0]    w4;
        logic [7:0]    b [3];
        d = word_of(w);
        w4 = 4'(w);
        b[0] = {~w4, d[19:16]};
        b[1] = d[15:8];
        b[2] = d[7:0];
        if (push) exp_q.push_back({w4, d});
        for (int i = 0; i < nbytes; i++) send_byte(b[i], $urandom_range(gapmax, 0));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_load(input int gapmax, input int cs_delta, input int start_at, input logic exp_err);
        int n;
        sum = 8'd0;
        pulse_start();
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_done_cleared", {31'd0, done}, 32'd0);
        for (int w = 0; w < 16; w++) begin
            if (w == start_at) pulse_start();
            send_word(w, 3, gapmax, 1'b1);
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'(8'd0 - sum + 8'(cs_delta)), 0);
`endif
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("run_done", {31'd0, done}, 32'd1);
        chk("run_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        chk("run_busy", {31'd0, busy}, 32'd0);
`ifdef PROG_LOADER_CHECKSUM_EN
        chk("run_err", {31'd0, err}, {31'd0, exp_err});
`else
        chk("run_err", {31'd0, err}, 32'd0);
`endif
        chk("run_queue_drained", exp_q.size(), 32'd0);
    endtask

    initial begin
        sum = 8'd0;
        // Reset asserted before any clock edge: outputs must already be zero.
        #2;
        chk("reset_outputs", {26'd0, rx_ready, wr_en, cpu_hold, busy, done, err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Bytes offered while idle are not consumed.
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        repeat (3) @(negedge clk);
        chk("idle_ignores_rx", {30'd0, rx_ready, busy}, 32'd0);
        rx_valid = 1'b0;

        // Back-to-back stream.
        run_load(0, 0, -1, 1'b0);
        repeat (5) begin
            @(negedge clk);
            chk("done_sticky", {31'd0, done}, 32'd1);
        end

        // Random valid gaps.
        run_load(3, 0, -1, 1'b0);

        // Start pulsed mid-run is ignored.
        run_load(1, 0, 7, 1'b0);

        // Reset after the 2nd byte of word 5.
        sum = 8'd0;
        pulse_start();
        for (int w = 0; w < 5; w++) send_word(w, 3, 0, 1'b1);
        send_word(5, 2, 0, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        chk("midrun_reset_outputs", {26'd0, rx_ready, wr_en, cpu_hold, busy, done, err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        chk("midrun_queue_drained", exp_q.size(), 32'd0);
        @(negedge clk);
        chk("after_reset_idle", {29'd0, rx_ready, busy, done}, 32'd0);
        run_load(0, 0, -1, 1'b0);

        // Checksum good, then off by one.
        run_load(2, 0, -1, 1'b0);
        run_load(0, 1, -1, 1'b1);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
